// File: rtl/opl3_timer_bank.sv
// Parametrised bank of OPL3-style interval timers: free-running tick generation,
// reload/start/mask control, sticky overflow flags and a combined IRQ.
module opl3_timer_bank #(
  parameter int NUM_TIMERS       = 2,
  parameter int TIMER_WIDTH      = 8,
  parameter int BASE_TICK_CYCLES = 1966,
  parameter int TICK_RATIO_LOG2  = 2,
  localparam int LIDX_W          = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_wr,
  input  logic [LIDX_W-1:0]      load_idx,
  input  logic [TIMER_WIDTH-1:0] load_data,
  input  logic                   ctrl_wr,
  input  logic                   ctrl_irq_rst,
  input  logic [NUM_TIMERS-1:0]  ctrl_mask,
  input  logic [NUM_TIMERS-1:0]  ctrl_start,
  output logic [NUM_TIMERS-1:0]  flag,
  output logic                   irq,
  output logic [NUM_TIMERS-1:0]  ovf_pulse
);

  localparam int PRE_W = (BASE_TICK_CYCLES > 1) ? $clog2(BASE_TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]       PRE_LAST     = PRE_W'(BASE_TICK_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] CNT_ALL_ONES = {TIMER_WIDTH{1'b1}};

  logic [PRE_W-1:0]       presc_r;
  logic                   base_tick_s;
  logic [NUM_TIMERS-1:0]  tick_s;

  logic [NUM_TIMERS-1:0]  start_r;
  logic [NUM_TIMERS-1:0]  mask_r;
  logic [NUM_TIMERS-1:0]  start_nxt_s;
  logic [NUM_TIMERS-1:0]  mask_nxt_s;

  logic [TIMER_WIDTH-1:0] reload_r     [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] cnt_r        [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] reload_nxt_s [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] cnt_nxt_s    [NUM_TIMERS];

  logic [NUM_TIMERS-1:0]  ovf_s;
  logic [NUM_TIMERS-1:0]  flag_nxt_s;
  logic [NUM_TIMERS-1:0]  flag_r;
  logic [NUM_TIMERS-1:0]  ovf_pulse_r;
  logic                   irq_r;

  assign base_tick_s = (presc_r == PRE_LAST);

  // Base prescaler: free-running, only reset_n touches its phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_r <= '0;
    end else if (base_tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRE_W'(1);
    end
  end

  assign tick_s[0] = base_tick_s;

  // Timer i ticks once per 2^(i*TICK_RATIO_LOG2) base ticks
  for (genvar gi = 1; gi < NUM_TIMERS; gi++) begin : g_sub
    localparam int DW = gi * TICK_RATIO_LOG2;
    if (DW == 0) begin : g_nodiv
      assign tick_s[gi] = base_tick_s;
    end else begin : g_div
      logic [DW-1:0] div_r;

      // Sub-divider: counts base ticks, wraps naturally at 2^DW
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          div_r <= '0;
        end else if (base_tick_s) begin
          div_r <= div_r + DW'(1);
        end else begin
          div_r <= div_r;
        end
      end

      assign tick_s[gi] = base_tick_s & (&div_r);
    end
  end

  // Next start/mask: an irq-reset write leaves both untouched
  always_comb begin
    start_nxt_s = start_r;
    mask_nxt_s  = mask_r;
    if (ctrl_wr && !ctrl_irq_rst) begin
      start_nxt_s = ctrl_start;
      mask_nxt_s  = ctrl_mask;
    end else begin
      start_nxt_s = start_r;
      mask_nxt_s  = mask_r;
    end
  end

  // Per-timer counting, reload and flag update
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      reload_nxt_s[i] = reload_r[i];
      cnt_nxt_s[i]    = cnt_r[i];
      ovf_s[i]        = 1'b0;
      flag_nxt_s[i]   = flag_r[i];

      if (load_wr && (load_idx == LIDX_W'(i))) begin
        reload_nxt_s[i] = load_data;
      end else begin
        reload_nxt_s[i] = reload_r[i];
      end

      // A tick coinciding with a start or a stop is dropped
      if (start_nxt_s[i] && !start_r[i]) begin
        cnt_nxt_s[i] = reload_nxt_s[i];
      end else if (start_nxt_s[i] && start_r[i] && tick_s[i]) begin
        if (cnt_r[i] == CNT_ALL_ONES) begin
          ovf_s[i]     = 1'b1;
          cnt_nxt_s[i] = reload_nxt_s[i];
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + TIMER_WIDTH'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end

      // Set beats irq-reset; a mask set by this same write beats the set
      if (ovf_s[i] && !mask_nxt_s[i]) begin
        flag_nxt_s[i] = 1'b1;
      end else if (ctrl_wr && (ctrl_irq_rst || ctrl_mask[i])) begin
        flag_nxt_s[i] = 1'b0;
      end else begin
        flag_nxt_s[i] = flag_r[i];
      end
    end
  end

  // Timer state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_r     <= '0;
      mask_r      <= '0;
      flag_r      <= '0;
      ovf_pulse_r <= '0;
      irq_r       <= 1'b0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        reload_r[i] <= '0;
        cnt_r[i]    <= '0;
      end
    end else begin
      start_r     <= start_nxt_s;
      mask_r      <= mask_nxt_s;
      flag_r      <= flag_nxt_s;
      ovf_pulse_r <= ovf_s;
      irq_r       <= |flag_nxt_s;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        reload_r[i] <= reload_nxt_s[i];
        cnt_r[i]    <= cnt_nxt_s[i];
      end
    end
  end

  assign flag      = flag_r;
  assign irq       = irq_r;
  assign ovf_pulse = ovf_pulse_r;

endmodule
